// File: rtl/mem_arbiter_if.sv
// Requester, sync-handshake and memory-bus signals of the shared memory slot.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  sync_pending;
  logic                  sync_strobe;
  logic                  sync_done;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  sync_strobe, sync_done, bus_rdata,
    output ack0, ack1, err, rdata, sync_pending, bus_addr, bus_we, bus_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output sync_strobe, sync_done, bus_rdata,
    input  ack0, ack1, err, rdata, sync_pending, bus_addr, bus_we, bus_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the interleaved memory slot between the SPI host
// bridge (requester 0) and video fetch (requester 1), with a pending-cycle timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  // Counter value on the last PENDING cycle before the abort fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_r;
  logic [7:0]            cnt_r;
  logic                  last_r;
  logic                  win_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  err_r;
  logic                  pending_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [ADDR_WIDTH-1:0] bus_addr_r;
  logic                  bus_we_r;
  logic [DATA_WIDTH-1:0] bus_wdata_r;

  logic                  any_req_s;
  logic                  grant_s;
  logic                  grant_we_s;
  logic [ADDR_WIDTH-1:0] grant_addr_s;
  logic [DATA_WIDTH-1:0] grant_wdata_s;
  logic                  unused_strobe_s;

  // Round-robin winner selection and the winner's request fields
  always_comb begin
    any_req_s     = bus.req0 | bus.req1;
    grant_s       = 1'b0;
    grant_we_s    = bus.we0;
    grant_addr_s  = bus.addr0;
    grant_wdata_s = bus.wdata0;
    if (bus.req0 && bus.req1) begin
      grant_s = ~last_r;
    end else if (bus.req1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      grant_we_s    = bus.we1;
      grant_addr_s  = bus.addr1;
      grant_wdata_s = bus.wdata1;
    end else begin
      grant_we_s    = bus.we0;
      grant_addr_s  = bus.addr0;
      grant_wdata_s = bus.wdata0;
    end
  end

  // Transaction FSM with registered handshake and bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      last_r      <= 1'b1;
      win_r       <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      err_r       <= 1'b0;
      pending_r   <= 1'b0;
      rdata_r     <= '0;
      bus_addr_r  <= '0;
      bus_we_r    <= 1'b0;
      bus_wdata_r <= '0;
    end else begin
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A still-high done from the previous slot blocks any new grant.
          if (any_req_s && !bus.sync_done) begin
            win_r       <= grant_s;
            last_r      <= grant_s;
            bus_we_r    <= grant_we_s;
            bus_addr_r  <= grant_addr_s;
            bus_wdata_r <= grant_wdata_s;
            pending_r   <= 1'b1;
            cnt_r       <= 8'd0;
            state_r     <= PENDING;
          end
        end
        PENDING: begin
          if (bus.sync_done) begin
            if (!bus_we_r) begin
              rdata_r <= bus.bus_rdata;
            end
            err_r     <= 1'b0;
            ack0_r    <= ~win_r;
            ack1_r    <= win_r;
            pending_r <= 1'b0;
            state_r   <= COMPLETE;
          end else if (cnt_r == CNT_LAST) begin
            err_r     <= 1'b1;
            ack0_r    <= ~win_r;
            ack1_r    <= win_r;
            pending_r <= 1'b0;
            state_r   <= COMPLETE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        COMPLETE: begin
          if (!bus.sync_done) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // The strobe only gates the memory write downstream.
  assign unused_strobe_s  = bus.sync_strobe;

  assign bus.ack0         = ack0_r;
  assign bus.ack1         = ack1_r;
  assign bus.err          = err_r;
  assign bus.rdata        = rdata_r;
  assign bus.sync_pending = pending_r;
  assign bus.bus_addr     = bus_addr_r;
  assign bus.bus_we       = bus_we_r;
  assign bus.bus_wdata    = bus_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset/abort sequences, a directed vector
// table and randomized transactions checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int TO = 4;

  typedef struct {
    logic          r0;
    logic          r1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    int            d;       // PENDING edges with done low before done is raised
    logic          hold;    // sync keeps done high one cycle into COMPLETE
    logic          drop;    // requesters drop req after the ack
    logic [DW-1:0] rv;
    logic          exp_win;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  string cur_tag = "init";
  logic          last_m;
  logic [DW-1:0] rdata_m;
  vec_t          tbl[9];
  vec_t          rv_v;
  int            r;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic r1, input logic we0, input logic we1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                              input int d, input logic hold, input logic drop,
                              input logic [DW-1:0] rv, input logic ew, input logic ee,
                              input logic [DW-1:0] er);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
    v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.d = d; v.hold = hold; v.drop = drop; v.rv = rv;
    v.exp_win = ew; v.exp_err = ee; v.exp_rdata = er;
    return v;
  endfunction

  // Runs one transaction starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic run_txn(input vec_t v);
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    int            done_c;
    int            ack_c;
    logic          hold_eff;
    bus_if.req0 = v.r0;   bus_if.req1 = v.r1;
    bus_if.we0 = v.we0;   bus_if.we1 = v.we1;
    bus_if.addr0 = v.a0;  bus_if.addr1 = v.a1;
    bus_if.wdata0 = v.wd0; bus_if.wdata1 = v.wd1;
    bus_if.sync_done = 1'b0;
    bus_if.bus_rdata = ~v.rv;
    ea  = v.exp_win ? v.a1  : v.a0;
    ewe = v.exp_win ? v.we1 : v.we0;
    ewd = v.exp_win ? v.wd1 : v.wd0;
    done_c   = v.d + 1;
    ack_c    = (done_c <= TO) ? done_c : TO;
    hold_eff = v.hold && (done_c <= TO);
    check("idle_pending", 32'(bus_if.sync_pending), 32'd0);
    @(posedge clk); @(negedge clk);
    check("grant_pending", 32'(bus_if.sync_pending), 32'd1);
    check("grant_addr",    32'(bus_if.bus_addr),     32'(ea));
    check("grant_we",      32'(bus_if.bus_we),       32'(ewe));
    check("grant_wdata",   32'(bus_if.bus_wdata),    32'(ewd));
    for (int c = 1; c <= ack_c; c++) begin
      if (c == done_c) begin
        bus_if.sync_done = 1'b1;
        bus_if.bus_rdata = v.rv;
      end
      @(posedge clk); @(negedge clk);
      if (c < ack_c) begin
        check("wait_pending", 32'(bus_if.sync_pending), 32'd1);
        check("wait_acks",    32'({bus_if.ack1, bus_if.ack0}), 32'd0);
        check("wait_addr",    32'(bus_if.bus_addr), 32'(ea));
        check("wait_wdata",   32'(bus_if.bus_wdata), 32'(ewd));
      end else begin
        check("ack_acks",    32'({bus_if.ack1, bus_if.ack0}), v.exp_win ? 32'd2 : 32'd1);
        check("ack_pending", 32'(bus_if.sync_pending), 32'd0);
        check("ack_err",     32'(bus_if.err),   32'(v.exp_err));
        check("ack_rdata",   32'(bus_if.rdata), 32'(v.exp_rdata));
      end
    end
    if (v.drop) begin
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
    end
    if (!hold_eff) bus_if.sync_done = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_acks",    32'({bus_if.ack1, bus_if.ack0}), 32'd0);
    check("post_pending", 32'(bus_if.sync_pending), 32'd0);
    if (hold_eff) begin
      bus_if.sync_done = 1'b0;
      @(posedge clk); @(negedge clk);
      check("hold_pending", 32'(bus_if.sync_pending), 32'd0);
    end
    last_m  = v.exp_win;
    rdata_m = v.exp_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus_if.req0 = 1'b1;  bus_if.req1 = 1'b0;
    bus_if.we0 = 1'b0;   bus_if.we1 = 1'b0;
    bus_if.addr0 = 17'h0ABCD; bus_if.addr1 = 17'h00000;
    bus_if.wdata0 = 8'h00; bus_if.wdata1 = 8'h00;
    bus_if.sync_strobe = 1'b0; bus_if.sync_done = 1'b0;
    bus_if.bus_rdata = 8'h00;

    // Reset held with a request pending: everything stays at reset values.
    cur_tag = "reset";
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pending",   32'(bus_if.sync_pending), 32'd0);
    check("acks",      32'({bus_if.ack1, bus_if.ack0}), 32'd0);
    check("err",       32'(bus_if.err), 32'd0);
    check("rdata",     32'(bus_if.rdata), 32'd0);
    check("bus_addr",  32'(bus_if.bus_addr), 32'd0);
    check("bus_we",    32'(bus_if.bus_we), 32'd0);
    check("bus_wdata", 32'(bus_if.bus_wdata), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("first_pending", 32'(bus_if.sync_pending), 32'd1);
    check("first_addr",    32'(bus_if.bus_addr), 32'h0ABCD);

    // Asynchronous reset in the middle of PENDING aborts silently.
    cur_tag = "midreset";
    #2 reset_n = 1'b0;
    #1;
    check("async_pending", 32'(bus_if.sync_pending), 32'd0);
    check("async_acks",    32'({bus_if.ack1, bus_if.ack0}), 32'd0);
    bus_if.req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("held_acks",     32'({bus_if.ack1, bus_if.ack0}), 32'd0);
    check("held_pending",  32'(bus_if.sync_pending), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    last_m  = 1'b1;
    rdata_m = 8'h00;

    tbl[0] = mk(1,1, 0,0, 17'h00010, 17'h00020, 8'h00, 8'h00,   0, 0,1, 8'h3C, 0,0, 8'h3C);
    tbl[1] = mk(0,1, 0,0, 17'h00000, 17'h1F000, 8'h00, 8'h00,   1, 1,1, 8'hA5, 1,0, 8'hA5);
    tbl[2] = mk(1,0, 1,0, 17'h00123, 17'h00000, 8'h5C, 8'h00,   2, 0,1, 8'hFF, 0,0, 8'hA5);
    tbl[3] = mk(0,1, 0,0, 17'h00000, 17'h0BEEF, 8'h00, 8'h00, 255, 0,1, 8'h77, 1,1, 8'hA5);
    tbl[4] = mk(1,1, 0,1, 17'h01000, 17'h02000, 8'h00, 8'h99,   0, 1,0, 8'h11, 0,0, 8'h11);
    tbl[5] = mk(1,1, 0,1, 17'h01001, 17'h02001, 8'h00, 8'h9A,   1, 0,0, 8'h22, 1,0, 8'h11);
    tbl[6] = mk(1,1, 0,0, 17'h01002, 17'h02002, 8'h00, 8'h00,   2, 1,0, 8'h33, 0,0, 8'h33);
    tbl[7] = mk(1,1, 0,0, 17'h01003, 17'h02003, 8'h00, 8'h00,   3, 0,1, 8'h44, 1,0, 8'h44);
    tbl[8] = mk(1,0, 1,0, 17'h1FFFF, 17'h00000, 8'hE7, 8'h00, 255, 1,1, 8'h55, 0,1, 8'h44);
    for (int i = 0; i < 9; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_txn(tbl[i]);
    end

    // Randomized transactions, expectations from the arbitration/timeout rules.
    for (int i = 0; i < 40; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      r = $urandom_range(1, 3);
      rv_v.r0   = r[0];
      rv_v.r1   = r[1];
      rv_v.we0  = 1'($urandom_range(0, 1));
      rv_v.we1  = 1'($urandom_range(0, 1));
      rv_v.a0   = 17'($urandom);
      rv_v.a1   = 17'($urandom);
      rv_v.wd0  = 8'($urandom);
      rv_v.wd1  = 8'($urandom);
      rv_v.d    = $urandom_range(0, 6);
      rv_v.hold = 1'($urandom_range(0, 1));
      rv_v.drop = 1'($urandom_range(0, 1));
      rv_v.rv   = 8'($urandom);
      rv_v.exp_win   = (rv_v.r0 && rv_v.r1) ? ~last_m : rv_v.r1;
      rv_v.exp_err   = (rv_v.d + 1 > TO);
      rv_v.exp_rdata = (!rv_v.exp_err && !(rv_v.exp_win ? rv_v.we1 : rv_v.we0)) ? rv_v.rv : rdata_m;
      run_txn(rv_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
